timer555_logic_core: RTL and testbench
======================================

Name: timer555_logic_core

Overview:
Parametrised digital control core for the HBT 555 timer. It sits between the analog comparator outputs and the output/discharge drivers, and handles CH independent channels. Each channel has input synchronisation, a glitch filter, and a 555-style latch with astable or monostable (retrigger-lockout) mode. Each channel also measures its high/low phase lengths and sets a sticky stuck-phase fault.

Parameters:
CH, 2, number of timer channels (must be >= 2)
FILT, 3, glitch-filter length in clk cycles; 0 = filter bypassed
CNT_W, 16, width of phase-length counters
TIMEOUT, 50000, phase length in cycles at which the stuck fault sets (must be < 2^CNT_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; 0 freezes all channel state, counters and faults
comp_trig  in  CH  trigger comparator per channel, 1 = voltage below 1/3 Vcc (asynchronous)
comp_thresh  in  CH  threshold comparator per channel, 1 = voltage above 2/3 Vcc (asynchronous)
ext_reset_n  in  CH  per-channel 555 reset pin, active low (asynchronous)
mode  in  CH  per channel: 0 = astable, 1 = monostable with lockout
fault_clr  in  CH  per-channel fault clear, sampled at clk
ch_sel  in  $clog2(CH)  channel selected for readout
out  out  CH  timer output per channel
discharge  out  CH  discharge transistor drive per channel, 1 = on
fault  out  CH  sticky stuck-phase fault per channel
hi_len  out  CNT_W  last completed HIGH length of channel ch_sel
lo_len  out  CNT_W  last completed LOW length (LOW + HOLDOFF) of channel ch_sel
meas_stb  out  1  1-cycle pulse when the ch_sel channel latches hi_len or lo_len

Behaviour:
- Reset (rst_n=0, asynchronous) values: out=0, discharge=1, fault=0, hi_len=0, lo_len=0, meas_stb=0, all states LOW, all counters 0, all synchronisers 0.
- Synchronisers: comp_trig, comp_thresh and ext_reset_n each pass through a 2-flop synchroniser per channel.
- Filter: a synchronised signal must hold a new value for FILT consecutive cycles before the filtered value changes. A glitch shorter than FILT cycles is ignored. With FILT=0 the filter is bypassed.
- Latency: an input edge to an out change takes 2 + FILT + 1 cycles.
- State machine (per channel): states LOW, HIGH, HOLDOFF.
- Output mapping: out=1 only in HIGH. discharge=1 in LOW and HOLDOFF.
- Priority, highest first:
  - filtered ext_reset_n=0: go to LOW from any state. Counters are cleared without latching.
  - trigger, then threshold.
- LOW -> HIGH: on filtered trig=1. This applies even if thresh=1 (trigger dominates, as in a bipolar 555).
- HIGH -> LOW: on filtered thresh=1 with trig=0.
  - Astable: trig=1 holds HIGH.
  - Monostable: thresh=1 with trig=1 goes to HOLDOFF.
- HOLDOFF -> LOW: when filtered trig=0. Trigger is ignored while in HOLDOFF. Astable never enters HOLDOFF.
- Mode changes take effect at the next transition.
- Phase counter:
  - Increments each enabled cycle and saturates at 2^CNT_W-1.
  - On leaving HIGH: the count+1 latches into that channel's hi_len register, and the counter restarts at 0.
  - On returning from LOW/HOLDOFF to HIGH: the count+1 latches into lo_len.
- meas_stb: fires in the cycle after a latch, but only for the channel equal to ch_sel in that cycle. The hi_len/lo_len outputs are a combinational mux of the per-channel registers.
- Fault:
  - Sets when the phase counter reaches TIMEOUT in any state.
  - Cleared only by fault_clr=1 or rst_n. fault_clr takes priority over a same-cycle set.
  - A fault does not alter timer behaviour.
- en=0: state, counters, filter counters and faults hold. Synchronisers keep running. out and discharge hold their values.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-HIGH -> out=0, discharge=1, fault=0, hi_len=lo_len=0 immediately, without waiting for clk.
- Astable timing, FILT=3: pulse trig for 10 cycles, then thresh after 20 cycles of HIGH -> out rises 6 cycles after the trig edge. hi_len equals the observed HIGH cycles, and meas_stb pulses once for ch_sel.
- Glitch filter, FILT=3: 2-cycle trig pulse -> out stays 0. 3-cycle pulse -> out rises.
- Monostable lockout: hold trig=1 through a thresh=1 event -> out=0, discharge=1 (HOLDOFF). Re-pulse trig while still held -> no output. Release trig, then pulse trig -> out=1 again.
- Priority: trig=1, thresh=1 and ext_reset_n=0 together -> out=0. Release ext_reset_n -> out=1 (trigger dominates).
- Fault: hold LOW for TIMEOUT cycles -> fault sets and stays set after HIGH. fault_clr=1 on the set cycle -> fault stays 0. Channel 1 fault leaves channel 0 fault unaffected.

Source files
------------

// File: rtl/timer555_logic_core.sv
// Digital control core for a multi-channel 555 timer: synchronises and deglitches the comparator
// inputs, runs the per-channel output latch, measures the phase lengths and flags stuck phases.
module timer555_logic_core #(
   parameter int CH      = 2,
   parameter int FILT    = 3,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [CH-1:0]         comp_trig,
   input  logic [CH-1:0]         comp_thresh,
   input  logic [CH-1:0]         ext_reset_n,
   input  logic [CH-1:0]         mode,
   input  logic [CH-1:0]         fault_clr,
   input  logic [$clog2(CH)-1:0] ch_sel,
   output logic [CH-1:0]         out,
   output logic [CH-1:0]         discharge,
   output logic [CH-1:0]         fault,
   output logic [CNT_W-1:0]      hi_len,
   output logic [CNT_W-1:0]      lo_len,
   output logic                  meas_stb
);
   localparam int SEL_W = $clog2(CH);
   localparam int FC_W  = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] T_OUT   = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {S_LOW = 2'd0, S_HIGH = 2'd1, S_HOLD = 2'd2} state_e;

   // Per-channel signal bundle: bit 0 = trig, bit 1 = thresh, bit 2 = ext_reset_n
   logic [2:0] sync1_q [CH];
   logic [2:0] sync2_q [CH];
   logic [2:0] filt    [CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            sync1_q[c] <= '0;
            sync2_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            sync1_q[c] <= {ext_reset_n[c], comp_thresh[c], comp_trig[c]};
            sync2_q[c] <= sync1_q[c];
         end
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_filt
      if (FILT == 0) begin : g_bypass
         assign filt[c] = sync2_q[c];
      end else begin : g_glitch
         logic [2:0]      val_q;
         logic [FC_W-1:0] run_q [3];

         // run_q counts consecutive samples disagreeing with the filtered value
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               val_q <= '0;
               for (int b = 0; b < 3; b++) run_q[b] <= '0;
            end else if (en) begin
               for (int b = 0; b < 3; b++) begin
                  if (sync2_q[c][b] == val_q[b]) begin
                     run_q[b] <= '0;
                  end else if (run_q[b] == FC_W'(FILT - 1)) begin
                     val_q[b] <= sync2_q[c][b];
                     run_q[b] <= '0;
                  end else begin
                     run_q[b] <= run_q[b] + 1'b1;
                  end
               end
            end
         end

         assign filt[c] = val_q;
      end
   end

   state_e           state_q [CH];
   state_e           state_d [CH];
   logic [CNT_W-1:0] cnt_q   [CH];
   logic [CNT_W-1:0] cnt_d   [CH];
   logic [CNT_W-1:0] hi_q    [CH];
   logic [CNT_W-1:0] hi_d    [CH];
   logic [CNT_W-1:0] lo_q    [CH];
   logic [CNT_W-1:0] lo_d    [CH];
   logic [CH-1:0]    fault_q, fault_d;
   logic [CH-1:0]    latch;
   logic             meas_stb_q, meas_stb_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            state_q[c] <= S_LOW;
            cnt_q[c]   <= '0;
            hi_q[c]    <= '0;
            lo_q[c]    <= '0;
         end
         fault_q    <= '0;
         meas_stb_q <= 1'b0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
            hi_q[c]    <= hi_d[c];
            lo_q[c]    <= lo_d[c];
         end
         fault_q    <= fault_d;
         meas_stb_q <= meas_stb_d;
      end
   end

   always_comb begin
      logic [CNT_W-1:0] inc;
      logic             trig, thr, rls;
      inc        = '0;
      trig       = 1'b0;
      thr        = 1'b0;
      rls        = 1'b0;
      latch      = '0;
      fault_d    = fault_q;
      meas_stb_d = 1'b0;
      for (int c = 0; c < CH; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         hi_d[c]    = hi_q[c];
         lo_d[c]    = lo_q[c];
         trig       = filt[c][0];
         thr        = filt[c][1];
         rls        = filt[c][2];
         inc        = (cnt_q[c] == CNT_MAX) ? CNT_MAX : cnt_q[c] + 1'b1;
         if (en) begin
            cnt_d[c] = inc;
            if (!rls) begin
               state_d[c] = S_LOW;
               cnt_d[c]   = '0;
            end else begin
               unique case (state_q[c])
                  S_LOW: begin
                     if (trig) begin
                        state_d[c] = S_HIGH;
                        lo_d[c]    = inc;
                        cnt_d[c]   = '0;
                        latch[c]   = 1'b1;
                     end
                  end
                  S_HIGH: begin
                     // Trigger still low-side in astable keeps the output high
                     if (thr && (!trig || mode[c])) begin
                        state_d[c] = trig ? S_HOLD : S_LOW;
                        hi_d[c]    = inc;
                        cnt_d[c]   = '0;
                        latch[c]   = 1'b1;
                     end
                  end
                  S_HOLD: begin
                     if (!trig) state_d[c] = S_LOW;
                  end
                  default: state_d[c] = S_LOW;
               endcase
            end
            if (fault_clr[c]) begin
               fault_d[c] = 1'b0;
            end else if (cnt_d[c] == T_OUT && cnt_q[c] != T_OUT) begin
               fault_d[c] = 1'b1;
            end
         end
      end
      for (int c = 0; c < CH; c++) begin
         if (ch_sel == SEL_W'(c) && latch[c]) meas_stb_d = 1'b1;
      end
   end

   always_comb begin
      out       = '0;
      discharge = '0;
      hi_len    = '0;
      lo_len    = '0;
      for (int c = 0; c < CH; c++) begin
         out[c]       = (state_q[c] == S_HIGH);
         discharge[c] = (state_q[c] != S_HIGH);
         if (ch_sel == SEL_W'(c)) begin
            hi_len = hi_q[c];
            lo_len = lo_q[c];
         end
      end
   end

   assign fault    = fault_q;
   assign meas_stb = meas_stb_q;

endmodule

// File: tb/tb_timer555_logic_core.sv
// Bench for timer555_logic_core: directed scenarios followed by random traffic, every cycle
// compared against a behavioural model of the timer built from delay lines and sample windows.
module tb_timer555_logic_core;
   localparam int CH      = 2;
   localparam int FILT    = 3;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 60;
   localparam int SEL_W   = $clog2(CH);
   localparam int MAXC    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n, en;
   logic [CH-1:0]    comp_trig, comp_thresh, ext_reset_n, mode, fault_clr;
   logic [SEL_W-1:0] ch_sel;
   logic [CH-1:0]    out, discharge, fault;
   logic [CNT_W-1:0] hi_len, lo_len;
   logic             meas_stb;

   timer555_logic_core #(.CH(CH), .FILT(FILT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .comp_trig(comp_trig), .comp_thresh(comp_thresh), .ext_reset_n(ext_reset_n),
      .mode(mode), .fault_clr(fault_clr), .ch_sel(ch_sel),
      .out(out), .discharge(discharge), .fault(fault),
      .hi_len(hi_len), .lo_len(lo_len), .meas_stb(meas_stb)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int mis = 0;

   // Model: raw pin delay line, window of the last FILT enabled samples, and the timer itself
   bit            m_d1 [CH][3];
   bit            m_d2 [CH][3];
   bit [FILT-1:0] m_win [CH][3];
   bit            m_f [CH][3];
   bit            m_high [CH];
   bit            m_lock [CH];
   bit            m_fault [CH];
   int            m_age [CH];
   int            m_hi [CH];
   int            m_lo [CH];
   bit            m_stb;

   function automatic bit pin(input int c, input int b);
      if (b == 0) return comp_trig[c];
      if (b == 1) return comp_thresh[c];
      return ext_reset_n[c];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         for (int b = 0; b < 3; b++) begin
            m_d1[c][b] = 0; m_d2[c][b] = 0; m_win[c][b] = '0; m_f[c][b] = 0;
         end
         m_high[c] = 0; m_lock[c] = 0; m_fault[c] = 0;
         m_age[c] = 0; m_hi[c] = 0; m_lo[c] = 0;
      end
      m_stb = 0;
   endtask

   task automatic model_step();
      bit got [CH];
      int nxt, prev;
      bit s;
      for (int c = 0; c < CH; c++) got[c] = 0;
      if (en) begin
         for (int c = 0; c < CH; c++) begin
            prev = m_age[c];
            nxt  = (m_age[c] >= MAXC) ? MAXC : m_age[c] + 1;
            if (!m_f[c][2]) begin
               m_high[c] = 0; m_lock[c] = 0; m_age[c] = 0;
            end else if (m_high[c]) begin
               if (m_f[c][1] && !m_f[c][0]) begin
                  m_high[c] = 0; m_hi[c] = nxt; m_age[c] = 0; got[c] = 1;
               end else if (m_f[c][1] && m_f[c][0] && mode[c]) begin
                  m_high[c] = 0; m_lock[c] = 1; m_hi[c] = nxt; m_age[c] = 0; got[c] = 1;
               end else m_age[c] = nxt;
            end else if (m_lock[c]) begin
               if (!m_f[c][0]) m_lock[c] = 0;
               m_age[c] = nxt;
            end else begin
               if (m_f[c][0]) begin
                  m_high[c] = 1; m_lo[c] = nxt; m_age[c] = 0; got[c] = 1;
               end else m_age[c] = nxt;
            end
            if (fault_clr[c]) m_fault[c] = 0;
            else if (m_age[c] == TIMEOUT && prev == TIMEOUT - 1) m_fault[c] = 1;
            for (int b = 0; b < 3; b++) begin
               s = m_d2[c][b];
               m_win[c][b] = {m_win[c][b][FILT-2:0], s};
               if (m_win[c][b] == {FILT{s}} && s != m_f[c][b]) m_f[c][b] = s;
            end
         end
      end
      m_stb = got[ch_sel];
      for (int c = 0; c < CH; c++)
         for (int b = 0; b < 3; b++) begin
            m_d2[c][b] = m_d1[c][b];
            m_d1[c][b] = pin(c, b);
         end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [CH-1:0] eo, ed, ef;
      for (int c = 0; c < CH; c++) begin
         eo[c] = m_high[c]; ed[c] = !m_high[c]; ef[c] = m_fault[c];
      end
      chk("cycle", {out, discharge, fault, hi_len, lo_len, meas_stb},
          {eo, ed, ef, CNT_W'(m_hi[ch_sel]), CNT_W'(m_lo[ch_sel]), m_stb});
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         if (rst_n) model_step();
         #1 compare_all();
      end
   endtask

   task automatic wait_out(input int c, input bit v, input int bound, output int k);
      k = 0;
      while (out[c] !== v && k < bound) begin
         step(1);
         k++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, hcnt, scnt;
      rst_n = 0; en = 1; comp_trig = '0; comp_thresh = '0; ext_reset_n = '1;
      mode = '0; fault_clr = '0; ch_sel = '0;
      model_reset();
      step(2);
      chk("reset_state", {out, discharge, fault, hi_len, lo_len, meas_stb},
          {2'b00, 2'b11, 2'b00, 32'h0, 1'b0});
      rst_n = 1;
      step(12);

      // Astable: 10-cycle trigger, threshold after 20 HIGH cycles
      comp_trig[0] = 1;
      wait_out(0, 1, 20, k);
      chk("astable_latency", k, 6);
      hcnt = 1; scnt = 0;
      step(4);
      hcnt += 4;
      comp_trig[0] = 0;
      while (hcnt < 20) begin step(1); if (out[0]) hcnt++; if (meas_stb) scnt++; end
      comp_thresh[0] = 1;
      k = 0;
      while (k < 20) begin
         step(1); k++;
         if (meas_stb) scnt++;
         if (!out[0]) break;
         hcnt++;
      end
      comp_thresh[0] = 0;
      repeat (8) begin step(1); if (meas_stb) scnt++; end
      chk("hi_len_observed", hi_len, hcnt);
      chk("hi_len_value", hi_len, 25);
      chk("meas_stb_once", scnt, 1);

      // Glitch filter
      step(5);
      comp_trig[0] = 1; step(2); comp_trig[0] = 0;
      hcnt = 0;
      repeat (12) begin step(1); if (out[0]) hcnt++; end
      chk("glitch2_ignored", hcnt, 0);
      comp_trig[0] = 1; step(3); comp_trig[0] = 0;
      wait_out(0, 1, 12, k);
      chk("pulse3_passes", k, 3);
      comp_thresh[0] = 1;
      wait_out(0, 0, 12, k);
      chk("thresh_ends_high", k, 6);
      comp_thresh[0] = 0;
      step(8);

      // Monostable lockout
      mode[0] = 1; comp_trig[0] = 1;
      wait_out(0, 1, 12, k);
      chk("mono_rise", k, 6);
      step(4);
      comp_thresh[0] = 1;
      wait_out(0, 0, 12, k);
      chk("mono_holdoff_entry", k, 6);
      step(4);
      chk("holdoff_discharge", discharge[0], 1'b1);
      comp_thresh[0] = 0;
      comp_trig[0] = 0; step(1); comp_trig[0] = 1;
      hcnt = 0;
      repeat (12) begin step(1); if (out[0]) hcnt++; end
      chk("holdoff_ignores_trig", hcnt, 0);
      comp_trig[0] = 0; step(10);
      chk("holdoff_released_low", out[0], 1'b0);
      comp_trig[0] = 1; step(4); comp_trig[0] = 0;
      wait_out(0, 1, 12, k);
      chk("mono_retrigger", k, 2);
      comp_thresh[0] = 1;
      wait_out(0, 0, 12, k);
      comp_thresh[0] = 0; mode[0] = 0;
      step(6);

      // Priority: ext reset over trigger, trigger over threshold
      ch_sel = 1;
      comp_trig[1] = 1; comp_thresh[1] = 1; ext_reset_n[1] = 0;
      step(15);
      chk("prio_reset_wins", out[1], 1'b0);
      ext_reset_n[1] = 1;
      wait_out(1, 1, 15, k);
      chk("prio_trig_dominates", k, 6);
      comp_trig[1] = 0;
      wait_out(1, 0, 15, k);
      chk("prio_thresh_ends", k, 6);
      comp_thresh[1] = 0;
      step(6);

      // Fault: both channels idle LOW, clear on channel 1 exactly on its set cycle
      ext_reset_n = '0; step(8);
      ext_reset_n = '1; fault_clr = '1; step(1); fault_clr = '0;
      chk("faults_cleared", fault, 2'b00);
      k = 0;
      while (m_age[1] != TIMEOUT - 1 && k < 200) begin step(1); k++; end
      chk("fault_wait_bound", k < 200, 1'b1);
      fault_clr[1] = 1; step(1); fault_clr[1] = 0;
      chk("clr_beats_set", fault[1], 1'b0);
      chk("ch0_fault_set", fault[0], 1'b1);
      step(5);
      chk("ch1_stays_clear", fault[1], 1'b0);
      comp_trig[0] = 1;
      wait_out(0, 1, 12, k);
      comp_trig[0] = 0;
      step(3);
      chk("fault_sticky_high", fault[0], 1'b1);

      // Asynchronous reset while channel 0 is HIGH
      ch_sel = 0;
      #2 rst_n = 0;
      #1 chk("async_reset", {out, discharge, fault, hi_len, lo_len, meas_stb},
             {2'b00, 2'b11, 2'b00, 32'h0, 1'b0});
      model_reset();
      step(2);
      rst_n = 1;
      step(8);

      // Random traffic
      repeat (700) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 9) == 0) comp_trig[c] = ~comp_trig[c];
            if ($urandom_range(0, 9) == 0) comp_thresh[c] = ~comp_thresh[c];
            if ($urandom_range(0, 59) == 0) ext_reset_n[c] = ~ext_reset_n[c];
            if ($urandom_range(0, 39) == 0) mode[c] = ~mode[c];
            fault_clr[c] = ($urandom_range(0, 29) == 0);
         end
         en = ($urandom_range(0, 9) != 0);
         ch_sel = SEL_W'($urandom_range(0, CH - 1));
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
